// File: rtl/store_buffer_if.sv
// Bus bundle between the MEM stage, store_buffer and memoryunit.
// Latency: none, wires only. Backpressure: st_ready and ld_stall travel back to the MEM stage.
// Ports: master = MEM stage side (drives st/ld/cpu/fence); slave = store_buffer.
interface store_buffer_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
);
   logic                     st_valid;
   logic                     st_ready;
   logic                     ld_valid;
   logic [ADDRESS_WIDTH-1:0] cpu_address;
   logic [DATA_WIDTH-1:0]    cpu_write_data;
   logic [2:0]               cpu_ctrl;
   logic                     fence;
   logic                     ld_stall;
   logic                     fwd_hit;
   logic [DATA_WIDTH-1:0]    fwd_data;
   logic [ADDRESS_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0]    mem_write_data;
   logic [2:0]               mem_ctrl;
   logic                     mem_write_enable;
   logic                     empty;
   logic                     fence_done;

   modport master (
      output st_valid, ld_valid, cpu_address, cpu_write_data, cpu_ctrl, fence,
      input  st_ready, ld_stall, fwd_hit, fwd_data, mem_address, mem_write_data,
             mem_ctrl, mem_write_enable, empty, fence_done
   );

   modport slave (
      input  st_valid, ld_valid, cpu_address, cpu_write_data, cpu_ctrl, fence,
      output st_ready, ld_stall, fwd_hit, fwd_data, mem_address, mem_write_data,
             mem_ctrl, mem_write_enable, empty, fence_done
   );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO in front of memoryunit's single port; owns the port mux, stalls loads that hit buffered stores.
// Latency: a store pushed at edge N may write memory at edge N+1 at the earliest; loads own the port in the same cycle.
// Backpressure: st_ready=0 when full or fencing; ld_stall holds the pipeline on word overlap or during a fence drain.
// Ports: clk, rst (sync, active-high), sb (store_buffer_if.slave: MEM-stage requests, memoryunit port, status).
// Optional store-to-load forwarding of an exact SW->LW match is enabled by defining STORE_FWD_EN.
module store_buffer #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DEPTH         = 4
) (
   input logic          clk,
   input logic          rst,
   store_buffer_if.slave sb
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [2:0] CTRL_WORD = 3'b010;

   typedef enum logic {S_RUN, S_FENCE} state_t;

   state_t                   state_q, state_d;
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            count_q, count_d;
   logic                     fence_done_q, fence_done_d;
   logic [ADDRESS_WIDTH-1:0] ent_addr_q [DEPTH];
   logic [ADDRESS_WIDTH-1:0] ent_addr_d [DEPTH];
   logic [DATA_WIDTH-1:0]    ent_data_q [DEPTH];
   logic [DATA_WIDTH-1:0]    ent_data_d [DEPTH];
   logic [2:0]               ent_ctrl_q [DEPTH];
   logic [2:0]               ent_ctrl_d [DEPTH];

   logic empty_w, full_w, hazard, fwd_hit_w, load_owns, drain, push;
`ifdef STORE_FWD_EN
   logic [PW-1:0] young_idx;
`endif

   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == CW'(DEPTH));

   // Scan oldest -> youngest over the live window; the last match seen is the youngest.
   always_comb begin
      hazard = 1'b0;
`ifdef STORE_FWD_EN
      young_idx = rd_ptr_q;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < count_q) &&
             (ent_addr_q[rd_ptr_q + PW'(k)][ADDRESS_WIDTH-1:2] == sb.cpu_address[ADDRESS_WIDTH-1:2])) begin
            hazard = sb.ld_valid;
`ifdef STORE_FWD_EN
            young_idx = rd_ptr_q + PW'(k);
`endif
         end
      end
   end

`ifdef STORE_FWD_EN
   // Only a full-word store to the exact load address can satisfy a full-word load.
   assign fwd_hit_w = hazard && (ent_ctrl_q[young_idx] == CTRL_WORD) &&
                      (sb.cpu_ctrl == CTRL_WORD) && (ent_addr_q[young_idx] == sb.cpu_address);
   assign sb.fwd_data = fwd_hit_w ? ent_data_q[young_idx] : '0;
`else
   assign fwd_hit_w   = 1'b0;
   assign sb.fwd_data = '0;
`endif

   // A hazarding (or forwarded) load never takes the port, so the buffer drains toward clearing it.
   assign load_owns   = sb.ld_valid && !hazard && (state_q == S_RUN);
   assign drain       = !empty_w && !load_owns;
   assign sb.st_ready = !full_w && (state_q == S_RUN);
   assign push        = sb.st_valid && sb.st_ready;

   assign sb.fwd_hit          = fwd_hit_w;
   assign sb.ld_stall         = sb.ld_valid && (hazard || (state_q == S_FENCE)) && !fwd_hit_w;
   assign sb.empty            = empty_w;
   assign sb.mem_write_enable = drain;
   assign sb.mem_address      = drain ? ent_addr_q[rd_ptr_q] : sb.cpu_address;
   assign sb.mem_write_data   = drain ? ent_data_q[rd_ptr_q] : sb.cpu_write_data;
   assign sb.mem_ctrl         = drain ? ent_ctrl_q[rd_ptr_q] : sb.cpu_ctrl;
   // A fence on an empty buffer completes immediately.
   assign sb.fence_done       = fence_done_q || ((state_q == S_RUN) && sb.fence && empty_w);

   always_comb begin
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(drain);
      count_d    = count_q + CW'(push) - CW'(drain);
      ent_addr_d = ent_addr_q;
      ent_data_d = ent_data_q;
      ent_ctrl_d = ent_ctrl_q;
      if (push) begin
         ent_addr_d[wr_ptr_q] = sb.cpu_address;
         ent_data_d[wr_ptr_q] = sb.cpu_write_data;
         ent_ctrl_d[wr_ptr_q] = sb.cpu_ctrl;
      end
   end

   always_comb begin
      state_d      = state_q;
      fence_done_d = 1'b0;
      case (state_q)
         S_RUN: begin
            if (sb.fence && !empty_w) state_d = S_FENCE;
         end
         S_FENCE: begin
            // Empty here only if the last entry left on the edge we entered; exit rather than hang.
            if (empty_w || (drain && (count_q == CW'(1)))) begin
               state_d      = S_RUN;
               fence_done_d = 1'b1;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_RUN;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         fence_done_q <= 1'b0;
         ent_addr_q   <= '{default: '0};
         ent_data_q   <= '{default: '0};
         ent_ctrl_q   <= '{default: '0};
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         fence_done_q <= fence_done_d;
         ent_addr_q   <= ent_addr_d;
         ent_data_q   <= ent_data_d;
         ent_ctrl_q   <= ent_ctrl_d;
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random load/store traffic against a queue-based model.
// Every cycle all outputs are compared with the model; directed steps add literal expectations.
// Ports: drives the store_buffer_if instance, clk and rst.
module tb_store_buffer;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   store_buffer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) sb_if ();

   store_buffer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  c;
   } ent_t;

   int   checks   = 0;
   int   failures = 0;
   ent_t q[$];
   bit   m_fence;
   bit   m_done;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, act, exp);
      end
   endtask

   task automatic drive(input bit sv, input bit lv, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] c, input bit f);
      sb_if.st_valid       = sv;
      sb_if.ld_valid       = lv;
      sb_if.cpu_address    = a;
      sb_if.cpu_write_data = d;
      sb_if.cpu_ctrl       = c;
      sb_if.fence          = f;
   endtask

   // Called at posedge+1 with inputs applied: checks outputs, crosses one edge, advances the model.
   task automatic step();
      ent_t        y;
      ent_t        ne;
      bit          hz, fwd, owns, drn, rdy, pushv, fdone;
      logic [31:0] fdat;
      int          sz;
      y   = '{default: '0};
      hz  = 1'b0;
      if (sb_if.ld_valid)
         foreach (q[i])
            if (q[i].a[31:2] == sb_if.cpu_address[31:2]) begin
               hz = 1'b1;
               y  = q[i];
            end
      fwd  = 1'b0;
      fdat = '0;
`ifdef STORE_FWD_EN
      if (hz && y.c == 3'b010 && sb_if.cpu_ctrl == 3'b010 && y.a == sb_if.cpu_address) begin
         fwd  = 1'b1;
         fdat = y.d;
      end
`endif
      sz    = q.size();
      owns  = sb_if.ld_valid && !hz && !m_fence;
      drn   = (sz != 0) && !owns;
      rdy   = (sz < DEPTH) && !m_fence;
      pushv = sb_if.st_valid && rdy;
      fdone = m_done || (!m_fence && sb_if.fence && sz == 0);
      ne.a  = sb_if.cpu_address;
      ne.d  = sb_if.cpu_write_data;
      ne.c  = sb_if.cpu_ctrl;
      #3;
      chk("st_ready", 32'(sb_if.st_ready), 32'(rdy));
      chk("empty", 32'(sb_if.empty), 32'(sz == 0));
      chk("ld_stall", 32'(sb_if.ld_stall), 32'(sb_if.ld_valid && (hz || m_fence) && !fwd));
      chk("fwd_hit", 32'(sb_if.fwd_hit), 32'(fwd));
      chk("fwd_data", sb_if.fwd_data, fdat);
      chk("mem_we", 32'(sb_if.mem_write_enable), 32'(drn));
      chk("mem_addr", sb_if.mem_address, drn ? q[0].a : ne.a);
      chk("mem_data", sb_if.mem_write_data, drn ? q[0].d : ne.d);
      chk("mem_ctrl", 32'(sb_if.mem_ctrl), 32'(drn ? q[0].c : ne.c));
      chk("fence_done", 32'(sb_if.fence_done), 32'(fdone));
      @(posedge clk);
      #1;
      m_done = 1'b0;
      if (!m_fence) begin
         if (sb_if.fence && sz != 0) m_fence = 1'b1;
      end else if (drn && sz == 1) begin
         m_fence = 1'b0;
         m_done  = 1'b1;
      end
      if (drn) q.delete(0);
      if (pushv) q.push_back(ne);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      m_fence = 1'b0;
      m_done  = 1'b0;
   endtask

   logic [31:0] dlist [4];
   logic [31:0] pool  [6];
   int          nwe;

   initial begin
      drive(0, 0, 32'h0, 32'h0, 3'b0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // reset state, passthrough
      drive(0, 0, 32'h0000_ABC0, 32'h5555_AAAA, 3'b100, 0);
      #1;
      chk("rst_st_ready", 32'(sb_if.st_ready), 32'd1);
      chk("rst_empty", 32'(sb_if.empty), 32'd1);
      chk("rst_ld_stall", 32'(sb_if.ld_stall), 32'd0);
      chk("rst_mem_we", 32'(sb_if.mem_write_enable), 32'd0);
      chk("rst_fence_done", 32'(sb_if.fence_done), 32'd0);
      chk("rst_mem_addr", sb_if.mem_address, 32'h0000_ABC0);
      step();

      // single SW drains on the next cycle
      drive(1, 0, 32'h100, 32'hDEADBEEF, 3'b010, 0);
      step();
      drive(0, 0, 32'h300, 32'h0, 3'b000, 0);
      #1;
      chk("sw_we", 32'(sb_if.mem_write_enable), 32'd1);
      chk("sw_addr", sb_if.mem_address, 32'h100);
      chk("sw_ctrl", 32'(sb_if.mem_ctrl), 32'(3'b010));
      chk("sw_data", sb_if.mem_write_data, 32'hDEADBEEF);
      step();
      #1;
      chk("sw_empty_after", 32'(sb_if.empty), 32'd1);
      step();

      // fill with a load holding the port, then drain in order
      dlist[0] = 32'h1111_0001; dlist[1] = 32'h2222_0002;
      dlist[2] = 32'h3333_0003; dlist[3] = 32'h4444_0004;
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 32'h10 + 32'(4 * i), dlist[i], 3'b010, 0);
         step();
      end
      drive(0, 1, 32'h200, 32'h0, 3'b010, 0);
      #1;
      chk("full_st_ready", 32'(sb_if.st_ready), 32'd0);
      chk("full_no_drain", 32'(sb_if.mem_write_enable), 32'd0);
      step();
      drive(0, 0, 32'h200, 32'h0, 3'b010, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("order_we", 32'(sb_if.mem_write_enable), 32'd1);
         chk("order_addr", sb_if.mem_address, 32'h10 + 32'(4 * i));
         chk("order_data", sb_if.mem_write_data, dlist[i]);
         step();
      end
      #1;
      chk("order_empty", 32'(sb_if.empty), 32'd1);
      step();

      // SB 0x101 then LW 0x100: stall while it drains, then load owns the port
      drive(1, 0, 32'h101, 32'h0000_00AB, 3'b000, 0);
      step();
      drive(0, 1, 32'h100, 32'h0, 3'b010, 0);
      #1;
      chk("haz_stall", 32'(sb_if.ld_stall), 32'd1);
      chk("haz_drain", 32'(sb_if.mem_write_enable), 32'd1);
      step();
      #1;
      chk("haz_clear", 32'(sb_if.ld_stall), 32'd0);
      chk("haz_load_owns", 32'(sb_if.mem_write_enable), 32'd0);
      chk("haz_load_addr", sb_if.mem_address, 32'h100);
      step();
      drive(0, 0, 32'h0, 32'h0, 3'b000, 0);
      step();

      // SW 0x40 then LW 0x40
      drive(1, 0, 32'h40, 32'h12345678, 3'b010, 0);
      step();
      drive(0, 1, 32'h40, 32'h0, 3'b010, 0);
      #1;
`ifdef STORE_FWD_EN
      chk("fwd_hit_sw_lw", 32'(sb_if.fwd_hit), 32'd1);
      chk("fwd_data_sw_lw", sb_if.fwd_data, 32'h12345678);
      chk("fwd_no_stall", 32'(sb_if.ld_stall), 32'd0);
`else
      chk("nofwd_hit", 32'(sb_if.fwd_hit), 32'd0);
      chk("nofwd_data", sb_if.fwd_data, 32'h0);
      chk("nofwd_stall", 32'(sb_if.ld_stall), 32'd1);
`endif
      step();
      drive(0, 0, 32'h0, 32'h0, 3'b000, 0);
      repeat (2) step();

      // fence with 3 entries queued
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 32'h80 + 32'(4 * i), 32'hF000_0000 + 32'(i), 3'b010, 0);
         step();
      end
      drive(0, 0, 32'h0, 32'h0, 3'b000, 1);
      nwe = 0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (sb_if.mem_write_enable) nwe++;
         if (c == 1) chk("fence_st_ready", 32'(sb_if.st_ready), 32'd0);
         if (c == 2) chk("fence_no_done_yet", 32'(sb_if.fence_done), 32'd0);
         if (c == 3) begin
            chk("fence_done_pulse", 32'(sb_if.fence_done), 32'd1);
            sb_if.fence = 1'b0;
         end
         if (c == 4) chk("fence_done_gone", 32'(sb_if.fence_done), 32'd0);
         step();
      end
      chk("fence_drains", 32'(nwe), 32'd3);

      // fence on an empty buffer completes combinationally
      drive(0, 0, 32'h0, 32'h0, 3'b000, 1);
      #1;
      chk("fence_empty_done", 32'(sb_if.fence_done), 32'd1);
      step();
      drive(0, 0, 32'h0, 32'h0, 3'b000, 0);
      step();

      // reset with 2 entries queued discards them
      for (int i = 0; i < 2; i++) begin
         drive(1, 1, 32'h60 + 32'(4 * i), 32'hCAFE_0000 + 32'(i), 3'b010, 0);
         step();
      end
      drive(0, 1, 32'h200, 32'h0, 3'b010, 0);
      do_reset();
      drive(0, 0, 32'h0, 32'h0, 3'b000, 0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("rst_mid_empty", 32'(sb_if.empty), 32'd1);
         chk("rst_mid_no_we", 32'(sb_if.mem_write_enable), 32'd0);
         step();
      end

      // random single-op-per-cycle traffic
      pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h101;
      pool[3] = 32'h102; pool[4] = 32'h108; pool[5] = 32'h200;
      for (int n = 0; n < 400; n++) begin
         int r;
         logic [31:0] a;
         logic [2:0]  sc, lc;
         r  = int'($urandom_range(0, 9));
         a  = pool[$urandom_range(0, 5)];
         sc = 3'($urandom_range(0, 2));
         lc = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b100;
         if (r < 4 && q.size() < DEPTH && !m_fence)
            drive(1, 0, a, $urandom, sc, 0);
         else if (r < 8)
            drive(0, 1, a, 32'h0, lc, 0);
         else
            drive(0, 0, a, $urandom, sc, 0);
         step();
      end
      drive(0, 0, 32'h0, 32'h0, 3'b000, 0);
      repeat (6) step();
      #1;
      chk("final_empty", 32'(sb_if.empty), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
